// File: rtl/axis_pkg.sv
// Shared AXI4-Stream helpers: byte-enable width rule and hold-register occupancy states.
package axis_pkg;

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_BUSY  = 1'b1;

   // One tkeep bit per data byte.
   function automatic int keep_w(input int width);
      return width / 8;
   endfunction

endpackage

// File: rtl/axis_lane_prio_enc.sv
// Lowest-set-bit index of a lane mask, plus a flag telling whether exactly one bit is set.
module axis_lane_prio_enc #(
   parameter  int N  = 2,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  pending,
   output logic [IW-1:0] idx,
   output logic          onehot
);

   always_comb begin
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (pending[i]) idx = IW'(i);
      end
   end

   assign onehot = (pending != '0) && ((pending & (pending - N'(1))) == '0);

endmodule

// File: rtl/axis_dwidth_downsizer_keep.sv
// AXI4-Stream downsizer: one wide beat becomes up to RATIO narrow beats, lane 0 first,
// null lanes optionally skipped, tlast on the last emitted lane.
module axis_dwidth_downsizer_keep
   import axis_pkg::*;
#(
   parameter int M_WIDTH   = 32,
   parameter int RATIO     = 2,
   parameter bit SKIP_NULL = 1'b1
) (
   input  logic                                 aclk,
   input  logic                                 areset,
   input  logic                                 s_axis_tvalid,
   output logic                                 s_axis_tready,
   input  logic [RATIO*M_WIDTH-1:0]             s_axis_tdata,
   input  logic [keep_w(RATIO*M_WIDTH)-1:0]     s_axis_tkeep,
   input  logic                                 s_axis_tlast,
   output logic                                 m_axis_tvalid,
   input  logic                                 m_axis_tready,
   output logic [M_WIDTH-1:0]                   m_axis_tdata,
   output logic [keep_w(M_WIDTH)-1:0]           m_axis_tkeep,
   output logic                                 m_axis_tlast
);

   localparam int KEEP_M  = keep_w(M_WIDTH);
   localparam int S_WIDTH = RATIO * M_WIDTH;
   localparam int KEEP_S  = keep_w(S_WIDTH);
   localparam int IW      = (RATIO > 1) ? $clog2(RATIO) : 1;

   logic [S_WIDTH-1:0] data_reg;
   logic [KEEP_S-1:0]  keep_reg;
   logic               last_reg;
   logic [RATIO-1:0]   pending_reg;
   logic [RATIO-1:0]   pending_next;
   logic               run_reg;

   logic [RATIO-1:0]   raw_mask;
   logic [RATIO-1:0]   word_mask;
   logic [IW-1:0]      lane_idx;
   logic               last_lane;
   logic [0:0]         state;
   logic               s_fire;
   logic               m_fire;

   logic [M_WIDTH-1:0] lane_data [RATIO];
   logic [KEEP_M-1:0]  lane_keep [RATIO];

   axis_lane_prio_enc #(.N(RATIO)) u_enc (
      .pending (pending_reg),
      .idx     (lane_idx),
      .onehot  (last_lane)
   );

   generate
      for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
         assign raw_mask[gi]  = SKIP_NULL ? (|s_axis_tkeep[gi*KEEP_M +: KEEP_M]) : 1'b1;
         assign lane_data[gi] = data_reg[gi*M_WIDTH +: M_WIDTH];
         assign lane_keep[gi] = keep_reg[gi*KEEP_M +: KEEP_M];
      end
   endgenerate

   // An all-null word still emits lane 0 so its tlast reaches the master side.
   assign word_mask = (raw_mask == '0) ? RATIO'(1) : raw_mask;

   assign state         = (pending_reg != '0) ? ST_BUSY : ST_EMPTY;
   assign m_axis_tvalid = (state == ST_BUSY);
   assign m_axis_tdata  = lane_data[lane_idx];
   assign m_axis_tkeep  = lane_keep[lane_idx];
   assign m_axis_tlast  = last_reg & last_lane;

   // Accept a new word while the final lane of the current one is leaving.
   assign s_axis_tready = run_reg & ((state == ST_EMPTY) | (m_axis_tready & last_lane));
   assign s_fire        = s_axis_tvalid & s_axis_tready;
   assign m_fire        = m_axis_tvalid & m_axis_tready;

   always_comb begin
      pending_next = pending_reg;
      if (s_fire) begin
         pending_next = word_mask;
      end else if (m_fire) begin
         pending_next = pending_reg & (pending_reg - RATIO'(1));
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         data_reg    <= '0;
         keep_reg    <= '0;
         last_reg    <= 1'b0;
         pending_reg <= '0;
         run_reg     <= 1'b0;
      end else begin
         run_reg     <= 1'b1;
         pending_reg <= pending_next;
         if (s_fire) begin
            data_reg <= s_axis_tdata;
            keep_reg <= s_axis_tkeep;
            last_reg <= s_axis_tlast;
         end
      end
   end

endmodule

// File: tb/tb_axis_dwidth_downsizer_keep.sv
// Drives three downsizer configurations with directed and random words and compares
// every master beat against a queue-based model of the lane-splitting rules.
module tb_axis_dwidth_downsizer_keep;

   localparam int NI = 3;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
   } beat_t;

   function automatic int rat_of(input int g);
      return (g == 0) ? 2 : 4;
   endfunction

   function automatic bit skip_of(input int g);
      return (g == 2) ? 1'b0 : 1'b1;
   endfunction

   logic         clk = 1'b0;
   logic         rst;
   logic         rst_q;
   int           cyc = 0;

   logic         sv [NI];
   logic         sr [NI];
   logic         sl [NI];
   logic [127:0] sd [NI];
   logic [15:0]  sk [NI];
   logic         mv [NI];
   logic         mr [NI];
   logic [31:0]  md [NI];
   logic [3:0]   mk [NI];
   logic         ml [NI];
   logic [1:0]   mode [NI];

   beat_t        exp_q [NI][$];
   int           hist_cyc [$];
   int           beat_cnt [NI];
   logic         stall_prev [NI];
   logic [36:0]  prev_out [NI];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= rst;
   end

   generate
      for (genvar gi = 0; gi < NI; gi++) begin : g_dut
         localparam int R = rat_of(gi);
         axis_dwidth_downsizer_keep #(
            .M_WIDTH   (32),
            .RATIO     (R),
            .SKIP_NULL (skip_of(gi))
         ) dut (
            .aclk          (clk),
            .areset        (rst),
            .s_axis_tvalid (sv[gi]),
            .s_axis_tready (sr[gi]),
            .s_axis_tdata  (sd[gi][R*32-1:0]),
            .s_axis_tkeep  (sk[gi][R*4-1:0]),
            .s_axis_tlast  (sl[gi]),
            .m_axis_tvalid (mv[gi]),
            .m_axis_tready (mr[gi]),
            .m_axis_tdata  (md[gi]),
            .m_axis_tkeep  (mk[gi]),
            .m_axis_tlast  (ml[gi])
         );
      end
   endgenerate

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference: the beats a word must produce, straight from the lane/keep rules.
   function automatic int expand(input logic [127:0] d, input logic [15:0] k, input logic l,
                                 input int ratio, input bit skip, output beat_t b [4]);
      int n;
      logic [3:0] kl;
      n = 0;
      for (int i = 0; i < 4; i++) b[i] = '0;
      for (int i = 0; i < ratio; i++) begin
         kl = k[i*4 +: 4];
         if (!skip || kl != 4'h0) begin
            b[n].data = d[i*32 +: 32];
            b[n].keep = kl;
            b[n].last = 1'b0;
            n++;
         end
      end
      if (n == 0) begin
         b[0].data = d[31:0];
         b[0].keep = 4'h0;
         n = 1;
      end
      b[n-1].last = l;
      return n;
   endfunction

   // Per-cycle comparison of every DUT against its expected-beat queue.
   always @(negedge clk) begin
      int    qs;
      int    n;
      beat_t e;
      beat_t bb [4];
      if (rst || rst_q) begin
         for (int g = 0; g < NI; g++) stall_prev[g] = 1'b0;
      end else begin
         for (int g = 0; g < NI; g++) begin
            qs = exp_q[g].size();
            if (stall_prev[g]) begin
               chk($sformatf("stall_valid%0d", g), 64'(mv[g]), 64'd1);
               chk($sformatf("stall_hold%0d", g), 64'({ml[g], mk[g], md[g]}), 64'(prev_out[g]));
            end
            chk($sformatf("m_valid%0d", g), 64'(mv[g]), 64'(qs != 0));
            chk($sformatf("s_ready%0d", g), 64'(sr[g]), 64'((qs == 0) || (qs == 1 && mr[g])));
            if (mv[g] && mr[g]) begin
               if (qs == 0) begin
                  chk($sformatf("unexpected_beat%0d", g), 64'd1, 64'd0);
               end else begin
                  e = exp_q[g].pop_front();
                  chk($sformatf("m_data%0d", g), 64'(md[g]), 64'(e.data));
                  chk($sformatf("m_keep%0d", g), 64'(mk[g]), 64'(e.keep));
                  chk($sformatf("m_last%0d", g), 64'(ml[g]), 64'(e.last));
               end
               beat_cnt[g]++;
               if (g == 0) hist_cyc.push_back(cyc);
            end
            if (sv[g] && sr[g]) begin
               n = expand(sd[g], sk[g], sl[g], rat_of(g), skip_of(g), bb);
               for (int i = 0; i < n; i++) exp_q[g].push_back(bb[i]);
               $display("word inst=%0d data=%h keep=%h last=%0d beats=%0d",
                        g, sd[g], sk[g], sl[g], n);
            end
            stall_prev[g] = mv[g] && !mr[g];
            prev_out[g]   = {ml[g], mk[g], md[g]};
         end
      end
   end

   initial begin
      for (int g = 0; g < NI; g++) mr[g] = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         for (int g = 0; g < NI; g++) begin
            case (mode[g])
               2'd0:    mr[g] = 1'b1;
               2'd1:    mr[g] = 1'($urandom_range(0, 1));
               2'd2:    mr[g] = ~mr[g];
               default: mr[g] = 1'b0;
            endcase
         end
      end
   end

   task automatic cycle_wait(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input int g, input logic [127:0] d, input logic [15:0] k, input logic l);
      bit done;
      int n;
      done = 1'b0;
      n = 0;
      sv[g] = 1'b1;
      sd[g] = d;
      sk[g] = k;
      sl[g] = l;
      while (!done) begin
         @(negedge clk);
         done = sr[g];
         @(posedge clk);
         #1;
         n++;
         if (!done && n > 200) begin
            chk($sformatf("send_timeout%0d", g), 64'd1, 64'd0);
            done = 1'b1;
         end
      end
      sv[g] = 1'b0;
   endtask

   function automatic logic [15:0] rand_keep();
      logic [15:0] k;
      for (int i = 0; i < 4; i++) begin
         case ($urandom_range(0, 3))
            0:       k[i*4 +: 4] = 4'h0;
            2:       k[i*4 +: 4] = 4'($urandom);
            default: k[i*4 +: 4] = 4'hF;
         endcase
      end
      return k;
   endfunction

   task automatic rand_traffic(input int g, input int words);
      for (int w = 0; w < words; w++) begin
         cycle_wait($urandom_range(0, 2));
         send(g, {$urandom, $urandom, $urandom, $urandom}, rand_keep(),
              1'($urandom_range(0, 2) == 0));
      end
   endtask

   task automatic check_reset(input int g);
      chk($sformatf("rst_s_ready%0d", g), 64'(sr[g]), 64'd0);
      chk($sformatf("rst_m_valid%0d", g), 64'(mv[g]), 64'd0);
      chk($sformatf("rst_m_data%0d", g), 64'(md[g]), 64'd0);
      chk($sformatf("rst_m_keep%0d", g), 64'(mk[g]), 64'd0);
      chk($sformatf("rst_m_last%0d", g), 64'(ml[g]), 64'd0);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 2000) begin
         cycle_wait(1);
         n++;
      end
      chk("drain_timeout", 64'(n >= 2000), 64'd0);
   endtask

   task automatic pin_model();
      beat_t b [4];
      int    n;
      logic [127:0] d4;
      d4 = 128'h44444444_33333333_22222222_11111111;
      n = expand(128'h00000001_00000064, 16'h00FF, 1'b0, 2, 1'b1, b);
      chk("pin_r2_n", 64'(n), 64'd2);
      chk("pin_r2_b0", 64'(b[0].data), 64'h64);
      chk("pin_r2_b1", 64'(b[1].data), 64'h1);
      chk("pin_r2_last", 64'(b[1].last), 64'd0);
      n = expand(d4, 16'h00FF, 1'b1, 4, 1'b1, b);
      chk("pin_00ff_n", 64'(n), 64'd2);
      chk("pin_00ff_last", 64'({b[0].last, b[1].last}), 64'b01);
      n = expand(d4, 16'hF00F, 1'b0, 4, 1'b1, b);
      chk("pin_f00f_n", 64'(n), 64'd2);
      chk("pin_f00f_b1", 64'(b[1].data), 64'h44444444);
      n = expand(d4, 16'hF00F, 1'b0, 4, 1'b0, b);
      chk("pin_noskip_n", 64'(n), 64'd4);
      chk("pin_noskip_keep", 64'({b[0].keep, b[1].keep, b[2].keep, b[3].keep}), 64'hF00F);
      n = expand(d4, 16'h0000, 1'b1, 4, 1'b1, b);
      chk("pin_null_n", 64'(n), 64'd1);
      chk("pin_null_beat", 64'({b[0].keep, b[0].last}), 64'b0000_1);
   endtask

   initial begin
      int b0;
      int n;
      logic [127:0] d4;
      d4 = 128'h44444444_33333333_22222222_11111111;
      rst = 1'b1;
      for (int g = 0; g < NI; g++) begin
         sv[g] = 1'b0; sd[g] = '0; sk[g] = '0; sl[g] = 1'b0;
         mode[g] = 2'd0; beat_cnt[g] = 0; stall_prev[g] = 1'b0;
      end
      cycle_wait(3);
      @(negedge clk);
      for (int g = 0; g < NI; g++) check_reset(g);
      @(posedge clk);
      #1;
      rst = 1'b0;
      cycle_wait(2);

      pin_model();

      // RATIO=2 back-to-back stream: eight beats on eight consecutive cycles.
      b0 = hist_cyc.size();
      send(0, 128'h00000001_00000064, 16'h00FF, 1'b0);
      for (int w = 1; w < 4; w++) send(0, {64'h0, $urandom, $urandom}, 16'h00FF, 1'b0);
      n = 0;
      while (hist_cyc.size() < b0 + 8 && n < 50) begin
         cycle_wait(1);
         n++;
      end
      if (hist_cyc.size() >= b0 + 8)
         chk("stream_span", 64'(hist_cyc[b0+7] - hist_cyc[b0]), 64'd7);
      else
         chk("stream_beats", 64'(hist_cyc.size() - b0), 64'd8);

      send(1, d4, 16'h00FF, 1'b1);
      send(1, d4, 16'hF00F, 1'b0);
      send(1, d4, 16'h0000, 1'b1);
      send(2, d4, 16'hF00F, 1'b1);
      drain();

      mode[1] = 2'd2;
      send(1, d4, 16'hFFFF, 1'b1);
      send(1, ~d4, 16'h0FF0, 1'b0);
      drain();

      for (int g = 0; g < NI; g++) mode[g] = 2'd1;
      fork
         rand_traffic(0, 50);
         rand_traffic(1, 50);
         rand_traffic(2, 50);
      join
      drain();

      // Reset while a word is stalled mid-split: it must vanish.
      mode[1] = 2'd3;
      send(1, d4, 16'hFFFF, 1'b1);
      cycle_wait(2);
      rst = 1'b1;
      for (int g = 0; g < NI; g++) exp_q[g].delete();
      @(negedge clk);
      check_reset(1);
      cycle_wait(2);
      rst = 1'b0;
      mode[1] = 2'd0;
      cycle_wait(4);
      @(negedge clk);
      chk("post_rst_m_valid", 64'(mv[1]), 64'd0);
      @(posedge clk);
      #1;
      send(1, ~d4, 16'hF0F0, 1'b1);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
